// File: rtl/rng_pkg.sv
// Shared types and constants for the random-word harvester.
package rng_pkg;

  localparam int unsigned LFSR_BITS = 16;
  localparam int unsigned DROP_W    = 8;

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_HARVEST = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rng_fifo.sv
// Synchronous first-word-fall-through FIFO. Entry 0 is always the head, so the
// head word and valid flag come straight from flops; unused entries read as 0.
module rng_fifo
  import rng_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty
);

  localparam int unsigned CW = cnt_w(DEPTH + 1);
  localparam int unsigned AW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             do_pop;
  logic             do_push;
  logic [AW-1:0]    wr_idx;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = ~valid;
  assign dout    = mem_q[0];
  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && (!full || do_pop);
  assign wr_idx  = AW'(cnt_q - CW'(do_pop));

  // Shift toward the head on pop, then write the new word behind the last entry.
  always_comb begin
    mem_d = mem_q;
    if (do_pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        mem_d[AW'(i)] = mem_q[AW'(i + 1)];
      end
      mem_d[AW'(DEPTH - 1)] = '0;
    end
    if (do_push) begin
      mem_d[wr_idx] = din;
    end
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[AW'(i)] <= '0;
      end
      cnt_q <= '0;
      valid <= 1'b0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      valid <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/rng_word_harvester.sv
// Decimates the LFSR bus into samples, drops a warm-up run, packs samples into
// words with a repetition health test, and queues words for a valid/ready sink.
module rng_word_harvester
  import rng_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DECIMATE     = 16,
  parameter int unsigned WARMUP       = 4,
  parameter int unsigned REPEAT_LIMIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [0:LFSR_BITS-1]  lfsr_in,
  input  logic                  enable,
  output logic [WIDTH-1:0]      rnd_data,
  output logic                  rnd_valid,
  input  logic                  rnd_ready,
  output logic                  fault,
  output logic [DROP_W-1:0]     drop_count
);

  localparam int unsigned WORDS = WIDTH / LFSR_BITS;
  localparam int unsigned DW    = cnt_w(DECIMATE);
  localparam int unsigned WW    = cnt_w(WARMUP);
  localparam int unsigned SW    = cnt_w(WORDS);
  localparam int unsigned RW    = cnt_w(REPEAT_LIMIT + 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [DW-1:0]          dcnt_q;
  logic [WW-1:0]          wcnt_q;
  logic [SW-1:0]          scnt_q;
  logic [RW-1:0]          rep_q;
  logic [RW-1:0]          rep_nxt;
  logic [LFSR_BITS-1:0]   prev_q;
  logic [LFSR_BITS-1:0]   sample;
  logic [WIDTH-1:0]       acc_q;
  logic [WIDTH-1:0]       acc_nxt;
  logic                   fault_q;
  logic [DROP_W-1:0]      drop_q;
  logic                   take;
  logic                   trip;
  logic                   word_done;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;

  // lfsr_in[0] lands in the sample MSB.
  assign sample    = lfsr_in;
  assign take      = enable && (dcnt_q == DW'(DECIMATE - 1));
  assign rep_nxt   = ((rep_q != '0) && (sample == prev_q)) ? rep_q + RW'(1) : RW'(1);
  assign trip      = take && (state_q != ST_FAULT) && (rep_nxt >= RW'(REPEAT_LIMIT));
  assign word_done = take && (state_q == ST_HARVEST) && (scnt_q == SW'(WORDS - 1));
  assign push      = word_done && !trip;
  assign pop       = rnd_ready && !fifo_empty;
  assign acc_nxt   = WIDTH'({acc_q, sample});

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= ST_WARMUP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WARMUP: begin
        if (trip) begin
          state_d = ST_FAULT;
        end else if (take && (wcnt_q == WW'(WARMUP - 1))) begin
          state_d = ST_HARVEST;
        end
      end
      ST_HARVEST: begin
        if (trip) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      dcnt_q  <= '0;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      rep_q   <= '0;
      prev_q  <= '0;
      acc_q   <= '0;
      fault_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      if (enable) begin
        dcnt_q <= (dcnt_q == DW'(DECIMATE - 1)) ? '0 : dcnt_q + DW'(1);
      end
      // Health test history; a zero rep count means no sample seen yet.
      if (take && (state_q != ST_FAULT)) begin
        prev_q <= sample;
        rep_q  <= rep_nxt;
      end
      if (take && (state_q == ST_WARMUP)) begin
        wcnt_q <= wcnt_q + WW'(1);
      end
      if (take && (state_q == ST_HARVEST)) begin
        if (word_done) begin
          acc_q  <= '0;
          scnt_q <= '0;
        end else begin
          acc_q  <= acc_nxt;
          scnt_q <= scnt_q + SW'(1);
        end
      end
      if (trip) begin
        fault_q <= 1'b1;
      end
      if (push && fifo_full && !pop && (drop_q != '1)) begin
        drop_q <= drop_q + DROP_W'(1);
      end
    end
  end

  rng_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (trip),
    .din   (acc_nxt),
    .dout  (rnd_data),
    .valid (rnd_valid),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fault      = fault_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_rng_word_harvester.sv
// Randomized bench for rng_word_harvester against a queue-based reference model.
module tb_rng_word_harvester;

  localparam int unsigned WIDTH        = 32;
  localparam int unsigned DECIMATE     = 16;
  localparam int unsigned WARMUP       = 4;
  localparam int unsigned REPEAT_LIMIT = 4;
  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned WORDS        = WIDTH / 16;

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic [0:15]      lfsr_in = '0;
  logic             enable = 1'b0;
  logic             rnd_ready = 1'b0;
  logic [WIDTH-1:0] rnd_data;
  logic             rnd_valid;
  logic             fault;
  logic [7:0]       drop_count;

  rng_word_harvester #(
    .WIDTH        (WIDTH),
    .DECIMATE     (DECIMATE),
    .WARMUP       (WARMUP),
    .REPEAT_LIMIT (REPEAT_LIMIT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .lfsr_in    (lfsr_in),
    .enable     (enable),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .fault      (fault),
    .drop_count (drop_count)
  );

  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  bit          chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: sample list, word queue and FIFO as plain queues.
  logic [WIDTH-1:0] m_q[$];
  logic [15:0]      m_hs[$];
  int unsigned      m_en = 0;
  int unsigned      m_nsamp = 0;
  int unsigned      m_rep = 0;
  int unsigned      m_drop = 0;
  int unsigned      cyc = 0;
  logic [15:0]      m_prev = '0;
  bit               m_fault = 1'b0;

  always @(posedge CLK) begin : model
    logic [15:0]      s;
    logic [WIDTH-1:0] w;
    bit               pop;
    bit               push;
    if (!reset) begin
      m_q.delete();
      m_hs.delete();
      m_en = 0; m_nsamp = 0; m_rep = 0; m_drop = 0; cyc = 0;
      m_prev = '0; m_fault = 1'b0;
    end else begin
      cyc++;
      pop = (m_q.size() != 0) && rnd_ready;
      push = 1'b0;
      w = '0;
      if (enable) begin
        m_en++;
        if ((m_en % DECIMATE) == 0 && !m_fault) begin
          s = lfsr_in;
          m_rep = (m_nsamp != 0 && s == m_prev) ? m_rep + 1 : 1;
          m_prev = s;
          if (m_rep >= REPEAT_LIMIT) begin
            m_fault = 1'b1;
            m_q.delete();
            m_hs.delete();
            pop = 1'b0;
          end else if (m_nsamp >= WARMUP) begin
            m_hs.push_back(s);
            if (m_hs.size() == WORDS) begin
              foreach (m_hs[j]) w = (w << 16) | WIDTH'(m_hs[j]);
              m_hs.delete();
              push = 1'b1;
            end
          end
          m_nsamp++;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(w);
        else if (m_drop < 255) m_drop++;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("rnd_valid", rnd_valid, (m_q.size() != 0));
      if (m_q.size() != 0) chk("rnd_data", rnd_data, m_q[0]);
      else chk("rnd_data", rnd_data, '0);
      chk("fault", fault, m_fault);
      chk("drop_count", drop_count, m_drop);
    end
  end

  // Stimulus
  int unsigned lmode = 0;
  logic [15:0] two_a = 16'h0001;
  logic [15:0] two_b = 16'h0002;

  task automatic drive_lfsr();
    int unsigned e;
    e = m_en + 1;
    case (lmode)
      0: lfsr_in = (((e - 1) / DECIMATE) % 2 != 0) ? 16'h5678 : 16'h1234;
      1: lfsr_in = 16'($urandom);
      2: lfsr_in = 16'hAAAA;
      3: lfsr_in = (e < 128) ? 16'($urandom) : ((e == 128) ? 16'h0F0F : 16'hC3C3);
      default: lfsr_in = ($urandom_range(0, 1) != 0) ? two_a : two_b;
    endcase
  endtask

  task automatic step();
    @(negedge CLK);
    drive_lfsr();
  endtask

  task automatic adv_to(input int unsigned n);
    int unsigned b;
    b = 0;
    while (m_en < n && b < 20000) begin
      step();
      b++;
    end
    chk("edge_reach", m_en, n);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_on = 1'b1;
    chk("rst_valid", rnd_valid, 1'b0);
    chk("rst_data", rnd_data, '0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_drop", drop_count, 8'd0);
  endtask

  initial begin
    // Warm-up timing and first word
    lmode = 0; enable = 1'b1; rnd_ready = 1'b0;
    do_reset();
    adv_to(95);
    chk("valid_before_96", rnd_valid, 1'b0);
    adv_to(96);
    chk("valid_at_97", rnd_valid, 1'b1);
    chk("first_word", rnd_data, 32'h1234_5678);
    chk("model_first_word", m_q[0], 32'h1234_5678);

    // Backpressure: 10 words completed by edge 384, 4 kept
    lmode = 1;
    adv_to(396);
    chk("bp_drop", drop_count, 8'd6);
    chk("bp_hold_data", rnd_data, 32'h1234_5678);
    chk("model_drop", m_drop, 6);

    // Pop aligned with the push at edge 416
    adv_to(415);
    rnd_ready = 1'b1;
    step();
    rnd_ready = 1'b0;
    chk("pushpop_drop", drop_count, 8'd6);
    chk("model_full", m_q.size(), FIFO_DEPTH);
    adv_to(448);
    chk("next_drop", drop_count, 8'd7);

    // Enable low for 50 cycles mid-word
    lmode = 0; enable = 1'b1;
    do_reset();
    adv_to(70);
    enable = 1'b0;
    repeat (50) step();
    enable = 1'b1;
    adv_to(95);
    chk("gap_valid_before", rnd_valid, 1'b0);
    adv_to(96);
    chk("gap_cycle", cyc, 146);
    chk("gap_valid", rnd_valid, 1'b1);
    chk("gap_word", rnd_data, 32'h1234_5678);

    // Reset mid-word restarts the whole warm-up
    adv_to(112);
    do_reset();
    adv_to(95);
    chk("rst2_valid_before", rnd_valid, 1'b0);
    adv_to(96);
    chk("rst2_word", rnd_data, 32'h1234_5678);

    // Health test on a stuck bus
    lmode = 2; rnd_ready = 1'b1;
    do_reset();
    adv_to(63);
    chk("stuck_fault_before", fault, 1'b0);
    adv_to(64);
    chk("stuck_fault", fault, 1'b1);
    chk("stuck_valid", rnd_valid, 1'b0);
    adv_to(160);
    chk("stuck_no_words", rnd_valid, 1'b0);

    // Fault while three words are queued; the fourth word loses to the fault
    lmode = 3; rnd_ready = 1'b0;
    do_reset();
    adv_to(191);
    chk("flush_valid_before", rnd_valid, 1'b1);
    chk("flush_fault_before", fault, 1'b0);
    chk("model_three", m_q.size(), 3);
    adv_to(192);
    chk("flush_valid", rnd_valid, 1'b0);
    chk("flush_fault", fault, 1'b1);
    lmode = 1; rnd_ready = 1'b1;
    repeat (50) step();
    chk("fault_sticky", fault, 1'b1);
    do_reset();

    // Random soak
    for (int seg = 0; seg < 15; seg++) begin
      lmode = ($urandom_range(0, 2) == 0) ? 4 : 1;
      two_a = 16'($urandom);
      two_b = 16'($urandom);
      if ($urandom_range(0, 1) != 0) do_reset();
      repeat (200) begin
        enable = ($urandom_range(0, 9) != 0);
        rnd_ready = ($urandom_range(0, 2) != 0);
        reset = ($urandom_range(0, 399) != 0);
        step();
      end
      reset = 1'b1;
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
